// File: rtl/alu_instr_sequencer_pkg.sv
// Shared types and constants for the ALU instruction sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state encoding, instruction field positions, opcode values, word decoder.
package alu_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FETCH    = 3'd1,
      ST_WAITSTEP = 3'd2,
      ST_ISSUE    = 3'd3,
      ST_SETTLE   = 3'd4,
      ST_DONE     = 3'd5
   } state_t;

   // Instruction word layout: [15]=halt, [14:12]=op, [11:8]=Rd, [7:4]=Rs, [3:0]=Rt
   localparam int HALT_BIT = 15;
   localparam int OP_HI    = 14;
   localparam int OP_LO    = 12;
   localparam int RD_HI    = 11;
   localparam int RD_LO    = 8;
   localparam int RS_HI    = 7;
   localparam int RS_LO    = 4;
   localparam int RT_HI    = 3;
   localparam int RT_LO    = 0;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRL = 3'b110;
   localparam logic [2:0] OP_SRA = 3'b111;

   typedef struct packed {
      logic       halt;
      logic [2:0] op;
      logic [3:0] rd;
      logic [3:0] rs;
      logic [3:0] rt;
   } instr_t;

   function automatic instr_t instr_decode(input logic [15:0] w);
      instr_t d;
      d.halt = w[HALT_BIT];
      d.op   = w[OP_HI:OP_LO];
      d.rd   = w[RD_HI:RD_LO];
      d.rs   = w[RS_HI:RS_LO];
      d.rt   = w[RT_HI:RT_LO];
      return d;
   endfunction

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// Bundle of program-load, control and issue signals of the sequencer.
// Latency: n/a (wires only).
// Backpressure: none; master drives load/control, slave drives issue/status.
interface alu_instr_sequencer_if #(parameter int AW = 4);

   logic          prog_we;
   logic [AW-1:0] prog_addr;
   logic [15:0]   prog_data;
   logic          start;
   logic          step_mode;
   logic          step;
   logic [2:0]    ALU_Operation;
   logic [3:0]    Rd;
   logic [3:0]    Rs;
   logic [3:0]    Rt;
   logic          execute;
   logic [AW-1:0] pc;
   logic          busy;
   logic          done;

   modport master (
      output prog_we, prog_addr, prog_data, start, step_mode, step,
      input  ALU_Operation, Rd, Rs, Rt, execute, pc, busy, done
   );

   modport slave (
      input  prog_we, prog_addr, prog_data, start, step_mode, step,
      output ALU_Operation, Rd, Rs, Rt, execute, pc, busy, done
   );

endinterface

// File: rtl/alu_instr_sequencer_sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous level followed by a rising-edge pulse.
// Latency: pulse is high the cycle after the second sync flop captures the rise.
// Backpressure: none; edges are not queued, each rise yields one 1-cycle pulse.
// Ports: clk, rst (async active-low), din (async level), pulse (1-cycle, registered sources).
module sync_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic pulse
);

   // sh[0], sh[1] are the synchroniser; sh[2] is the previous synchronised value
   logic [2:0] sh;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sh <= '0;
      end else begin
         sh <= {sh[1:0], din};
      end
   end

   assign pulse = sh[1] & ~sh[2];

endmodule

// File: rtl/alu_instr_sequencer.sv
// Holds a small ALU program and issues it one word at a time with an execute strobe.
// Latency: 1 FETCH + 1 ISSUE + GAP settle cycles per instruction; start/step act 3 cycles after input flop.
// Backpressure: none; optional single-step gating, start/step edges while not expected are dropped.
// Ports: clk, rst (async active-low), bus (slave: program load, start/step, opcode/regs, execute, pc, busy, done).
module alu_instr_sequencer #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int GAP   = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   alu_instr_sequencer_if.slave bus
);
   import alu_seq_pkg::*;

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [3:0]    GAP_LAST  = 4'(GAP - 1);

   state_t        state;
   logic [AW-1:0] pc_q;
   logic [3:0]    gap_cnt;
   logic [2:0]    op_q;
   logic [3:0]    rd_q;
   logic [3:0]    rs_q;
   logic [3:0]    rt_q;
   logic          exec_q;
   logic          busy_q;
   logic          done_q;

   logic [15:0]   mem [DEPTH];
   logic [15:0]   word_q;
   logic [AW-1:0] rd_addr;
   instr_t        word;
   logic          start_pulse;
   logic          step_pulse;
   logic          idle_or_done;
   logic          settle_last;

   sync_edge_detect u_start_sync (.clk(clk), .rst(rst), .din(bus.start), .pulse(start_pulse));
   sync_edge_detect u_step_sync  (.clk(clk), .rst(rst), .din(bus.step),  .pulse(step_pulse));

   assign idle_or_done = (state == ST_IDLE) || (state == ST_DONE);
   assign settle_last  = (state == ST_SETTLE) && (gap_cnt == GAP_LAST);
   assign word         = instr_decode(word_q);

   // The buffer read is registered, so present the address pc is about to take:
   // that way word_q already holds buffer[pc] during the FETCH cycle.
   always_comb begin
      rd_addr = pc_q;
      if (idle_or_done && start_pulse) begin
         rd_addr = '0;
      end else if (settle_last && (pc_q != LAST_ADDR)) begin
         rd_addr = pc_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (bus.prog_we && idle_or_done) begin
         mem[bus.prog_addr] <= bus.prog_data;
      end
      word_q <= mem[rd_addr];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         pc_q    <= '0;
         gap_cnt <= '0;
         op_q    <= '0;
         rd_q    <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         exec_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         exec_q <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start_pulse) begin
                  state  <= ST_FETCH;
                  pc_q   <= '0;
                  busy_q <= 1'b1;
                  done_q <= 1'b0;
               end
            end
            ST_FETCH: begin
               if (word.halt) begin
                  // halt word is never issued; outputs keep the last issued fields
                  state  <= ST_DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end else begin
                  op_q <= word.op;
                  rd_q <= word.rd;
                  rs_q <= word.rs;
                  rt_q <= word.rt;
                  if (bus.step_mode) begin
                     state <= ST_WAITSTEP;
                  end else begin
                     state  <= ST_ISSUE;
                     exec_q <= 1'b1;
                  end
               end
            end
            ST_WAITSTEP: begin
               if (step_pulse) begin
                  state  <= ST_ISSUE;
                  exec_q <= 1'b1;
               end
            end
            ST_ISSUE: begin
               state   <= ST_SETTLE;
               gap_cnt <= '0;
            end
            ST_SETTLE: begin
               if (gap_cnt == GAP_LAST) begin
                  gap_cnt <= '0;
                  if (pc_q == LAST_ADDR) begin
                     state  <= ST_DONE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end else begin
                     pc_q  <= pc_q + 1'b1;
                     state <= ST_FETCH;
                  end
               end else begin
                  gap_cnt <= gap_cnt + 4'd1;
               end
            end
            default: begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ALU_Operation = op_q;
   assign bus.Rd            = rd_q;
   assign bus.Rs            = rs_q;
   assign bus.Rt            = rt_q;
   assign bus.execute       = exec_q;
   assign bus.pc            = pc_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Self-checking bench for alu_instr_sequencer: random programs against a program-walk reference model.
module tb_alu_instr_sequencer;
   import alu_seq_pkg::*;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int GAP   = 2;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_instr_sequencer_if #(.AW(AW)) bus ();

   alu_instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .GAP(GAP)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic [2:0]    op;
      logic [3:0]    rd;
      logic [3:0]    rs;
      logic [3:0]    rt;
      logic [AW-1:0] pc;
      int            cyc;
   } ex_t;

   ex_t           seen_q[$];
   ex_t           exp_q[$];
   logic [15:0]   prog [DEPTH];
   logic [AW-1:0] exp_pc;

   // record every execute strobe, sampled mid-cycle
   always @(negedge clk) begin
      if (bus.execute === 1'b1) begin
         ex_t e;
         e.op  = bus.ALU_Operation;
         e.rd  = bus.Rd;
         e.rs  = bus.Rs;
         e.rt  = bus.Rt;
         e.pc  = bus.pc;
         e.cyc = cyc;
         seen_q.push_back(e);
      end
   end

   // Reference: walk the program from address 0, issue every word until a halt
   // word (not issued, pc stays there) or the last address (no wrap).
   task automatic build_model();
      ex_t e;
      exp_q.delete();
      exp_pc = '0;
      for (int a = 0; a < DEPTH; a++) begin
         exp_pc = AW'(a);
         if (prog[a][15]) break;
         e.op  = prog[a][14:12];
         e.rd  = prog[a][11:8];
         e.rs  = prog[a][7:4];
         e.rt  = prog[a][3:0];
         e.pc  = AW'(a);
         e.cyc = 0;
         exp_q.push_back(e);
      end
   endtask

   task automatic load_prog();
      for (int a = 0; a < DEPTH; a++) begin
         @(negedge clk);
         bus.prog_we   = 1'b1;
         bus.prog_addr = AW'(a);
         bus.prog_data = prog[a];
      end
      @(negedge clk);
      bus.prog_we = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      bus.start = 1'b1;
      repeat (2) @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!(bus.done === 1'b1 && bus.busy === 1'b0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 300) begin
         errors++;
         $display("FAIL %s_timeout: done=%b busy=%b after %0d cycles, required done=1", name, bus.done, bus.busy, n);
      end
   endtask

   task automatic run_and_wait(input string name);
      int n = 0;
      seen_q.delete();
      pulse_start();
      while (bus.busy !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 20) begin
         errors++;
         $display("FAIL %s_start: busy never rose, required busy=1 after start", name);
      end
      wait_done(name);
   endtask

   task automatic check_run(input string name);
      int n;
      checks++;
      if (seen_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL %s_count: got %0d execute pulses, required %0d", name, seen_q.size(), exp_q.size());
      end
      n = (seen_q.size() < exp_q.size()) ? seen_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if ({seen_q[i].op, seen_q[i].rd, seen_q[i].rs, seen_q[i].rt, seen_q[i].pc} !==
             {exp_q[i].op, exp_q[i].rd, exp_q[i].rs, exp_q[i].rt, exp_q[i].pc}) begin
            errors++;
            $display("FAIL %s_instr%0d: got op=%0h rd=%0h rs=%0h rt=%0h pc=%0h, required op=%0h rd=%0h rs=%0h rt=%0h pc=%0h",
                     name, i, seen_q[i].op, seen_q[i].rd, seen_q[i].rs, seen_q[i].rt, seen_q[i].pc,
                     exp_q[i].op, exp_q[i].rd, exp_q[i].rs, exp_q[i].rt, exp_q[i].pc);
         end
         if (i > 0) begin
            checks++;
            if (seen_q[i].cyc - seen_q[i-1].cyc != 2 + GAP) begin
               errors++;
               $display("FAIL %s_spacing%0d: got %0d cycles between executes, required %0d",
                        name, i, seen_q[i].cyc - seen_q[i-1].cyc, 2 + GAP);
            end
         end
      end
      checks++;
      if (bus.pc !== exp_pc) begin
         errors++;
         $display("FAIL %s_pc: got %0h, required %0h", name, bus.pc, exp_pc);
      end
      checks++;
      if ({bus.done, bus.busy, bus.execute} !== 3'b100) begin
         errors++;
         $display("FAIL %s_status: got done/busy/execute=%b, required 100", name, {bus.done, bus.busy, bus.execute});
      end
   endtask

   task automatic test_reset();
      rst            = 1'b0;
      bus.prog_we    = 1'b0;
      bus.prog_addr  = '0;
      bus.prog_data  = '0;
      bus.start      = 1'b0;
      bus.step_mode  = 1'b0;
      bus.step       = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.pc, bus.ALU_Operation, bus.Rd, bus.Rs, bus.Rt} !== '0) begin
         errors++;
         $display("FAIL reset_fields: got pc=%0h op=%0h rd=%0h rs=%0h rt=%0h, required all 0",
                  bus.pc, bus.ALU_Operation, bus.Rd, bus.Rs, bus.Rt);
      end
      checks++;
      if ({bus.execute, bus.busy, bus.done} !== 3'b000) begin
         errors++;
         $display("FAIL reset_status: got execute/busy/done=%b, required 000", {bus.execute, bus.busy, bus.done});
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      for (int a = 0; a < DEPTH; a++) prog[a] = 16'($urandom);
      prog[0] = 16'h0123;
      prog[1] = 16'h8000;
      load_prog();
      build_model();
      run_and_wait("single");
      check_run("single");
      checks++;
      if (seen_q.size() != 1 || seen_q[0].op !== OP_ADD || seen_q[0].rd !== 4'd1) begin
         errors++;
         $display("FAIL single_add: got %0d pulses, first op/rd=%0h/%0h, required 1 pulse op=0 rd=1",
                  seen_q.size(), (seen_q.size() > 0) ? seen_q[0].op : 3'h0, (seen_q.size() > 0) ? seen_q[0].rd : 4'h0);
      end
   endtask

   task automatic test_full_run();
      int n0;
      for (int a = 0; a < DEPTH; a++) prog[a] = {1'b0, 3'($urandom), 4'(a), 8'($urandom)};
      load_prog();
      build_model();
      run_and_wait("full");
      check_run("full");
      n0 = seen_q.size();
      repeat (20) @(negedge clk);
      checks++;
      if (seen_q.size() != n0 || bus.pc !== AW'(DEPTH - 1)) begin
         errors++;
         $display("FAIL full_nowrap: got %0d extra pulses pc=%0h, required 0 extra pc=%0h",
                  seen_q.size() - n0, bus.pc, DEPTH - 1);
      end
   endtask

   task automatic test_step();
      int t0;
      int n = 0;
      for (int a = 0; a < DEPTH; a++) prog[a] = 16'($urandom);
      prog[0] = 16'h1456;
      prog[1] = 16'h8000;
      load_prog();
      bus.step_mode = 1'b1;
      seen_q.delete();
      pulse_start();
      repeat (20) @(negedge clk);
      checks++;
      if (seen_q.size() != 0 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL step_wait: got %0d pulses busy=%b before step, required 0 pulses busy=1", seen_q.size(), bus.busy);
      end
      bus.step = 1'b1;
      t0 = cyc;
      while (seen_q.size() == 0 && n < 12) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (seen_q.size() == 0) begin
         errors++;
         $display("FAIL step_issue: no execute after step edge, required one");
      end else begin
         checks++;
         if (seen_q[0].cyc - t0 < 3 || seen_q[0].cyc - t0 > 4) begin
            errors++;
            $display("FAIL step_latency: got %0d cycles, required 3..4", seen_q[0].cyc - t0);
         end
         checks++;
         if ({seen_q[0].op, seen_q[0].rd, seen_q[0].rs, seen_q[0].rt} !== {OP_SUB, 4'd4, 4'd5, 4'd6}) begin
            errors++;
            $display("FAIL step_fields: got op=%0h rd=%0h rs=%0h rt=%0h, required 1 4 5 6",
                     seen_q[0].op, seen_q[0].rd, seen_q[0].rs, seen_q[0].rt);
         end
      end
      wait_done("step");
      repeat (10) @(negedge clk);
      checks++;
      if (seen_q.size() != 1 || bus.pc !== AW'(1)) begin
         errors++;
         $display("FAIL step_hold: got %0d pulses pc=%0h with step held, required 1 pulse pc=1", seen_q.size(), bus.pc);
      end
      bus.step      = 1'b0;
      bus.step_mode = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int n = 0;
      for (int a = 0; a < DEPTH; a++) prog[a] = (16'($urandom) & 16'h7FFF) | 16'h0111;
      prog[5] = 16'h8000 | 16'($urandom);
      load_prog();
      build_model();
      seen_q.delete();
      pulse_start();
      while (seen_q.size() < 3 && n < 60) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b1 || bus.pc !== AW'(2)) begin
         errors++;
         $display("FAIL rstmid_pre: got busy=%b pc=%0h in settle, required busy=1 pc=2", bus.busy, bus.pc);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({bus.pc, bus.ALU_Operation, bus.Rd, bus.Rs, bus.Rt, bus.execute, bus.busy, bus.done} !== '0) begin
         errors++;
         $display("FAIL rstmid_async: got pc=%0h op=%0h rd=%0h rs=%0h rt=%0h ex/busy/done=%b, required all 0",
                  bus.pc, bus.ALU_Operation, bus.Rd, bus.Rs, bus.Rt, {bus.execute, bus.busy, bus.done});
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.execute} !== 3'b000 || bus.pc !== '0) begin
         errors++;
         $display("FAIL rstmid_idle: got busy/done/ex=%b pc=%0h, required 000 pc=0", {bus.busy, bus.done, bus.execute}, bus.pc);
      end
      run_and_wait("rstmid_rerun");
      check_run("rstmid_rerun");
   endtask

   task automatic test_busy_ignore();
      int n = 0;
      for (int a = 0; a < DEPTH; a++) prog[a] = 16'($urandom) & 16'h7FFF;
      prog[4] = 16'h8000;
      load_prog();
      build_model();
      seen_q.delete();
      pulse_start();
      while (seen_q.size() < 2 && n < 60) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      bus.prog_we   = 1'b1;
      bus.prog_addr = '0;
      bus.prog_data = 16'h8000;
      bus.start     = 1'b1;
      @(negedge clk);
      bus.prog_we = 1'b0;
      repeat (2) @(negedge clk);
      bus.start = 1'b0;
      wait_done("busy");
      check_run("busy");
      run_and_wait("busy_rerun");
      check_run("busy_rerun");
   endtask

   task automatic test_halt_first();
      for (int a = 0; a < DEPTH; a++) prog[a] = 16'($urandom) & 16'h7FFF;
      prog[0] = 16'h8FFF;
      load_prog();
      build_model();
      run_and_wait("halt0");
      check_run("halt0");
   endtask

   task automatic test_random();
      for (int it = 0; it < 4; it++) begin
         int h = $urandom_range(1, DEPTH);
         for (int a = 0; a < DEPTH; a++) prog[a] = 16'($urandom) & 16'h7FFF;
         if (h < DEPTH) prog[h] = prog[h] | 16'h8000;
         load_prog();
         build_model();
         run_and_wait("random");
         check_run("random");
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_full_run();
      test_step();
      test_reset_mid();
      test_busy_ignore();
      test_halt_first();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_instr_sequencer.md
Name: alu_instr_sequencer

Overview:
Upstream control stage for the register/ALU datapath. It holds a small program of packed ALU instructions, loaded from switches or a host, then issues them one at a time. Each issued instruction drives the ALU opcode and the Rd/Rs/Rt register addresses, plus a single-cycle execute (write-enable) strobe. It supports free-run and single-step modes, and halts on a halt-flagged word or at the end of the program buffer.

Parameters:
DEPTH, 16, number of instruction words in the program buffer (power of two)
AW, 4, address width, log2(DEPTH)
GAP, 2, idle cycles after each execute strobe before the next fetch (register write settle); legal range 1..15

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
prog_we  input  1  write one program word this cycle (ignored unless state is IDLE or DONE)
prog_addr  input  AW  program write address
prog_data  input  16  instruction word: [15]=halt, [14:12]=ALU_Operation, [11:8]=Rd, [7:4]=Rs, [3:0]=Rt
start  input  1  level or pulse; rising edge begins execution at address 0
step_mode  input  1  1 = wait for a step edge before each issue, 0 = free-run
step  input  1  asynchronous button; synchronised and edge-detected internally
ALU_Operation  output  3  opcode to the ALU stage
Rd  output  4  destination register
Rs  output  4  source register
Rt  output  4  second source register
execute  output  1  one-cycle write strobe to the register bank
pc  output  AW  address of the current or last issued instruction
busy  output  1  high in every state except IDLE and DONE
done  output  1  high in DONE

Behaviour:
- Reset (rst low, asynchronous): state IDLE, pc=0, ALU_Operation/Rd/Rs/Rt=0, execute=0, busy=0, done=0, GAP counter=0, synchroniser flops=0. Program buffer contents are not reset.
- Program buffer: synchronous write on prog_we in IDLE/DONE only; prog_we in any other state has no effect. Read is registered, 1 cycle.
- Inputs start and step each pass through a 2-flop synchroniser, then a rising-edge detector. Edge-to-action latency is 3 cycles after the input flop.
- FSM states: IDLE, FETCH, WAITSTEP, ISSUE, SETTLE, DONE.
  - IDLE: on start edge -> FETCH with pc=0.
  - DONE: on start edge -> FETCH with pc=0 (rerun).
  - FETCH, 1 cycle: read buffer[pc]. Next state is DONE if halt=1, otherwise WAITSTEP if step_mode=1, otherwise ISSUE.
  - Halt word: the halted word is never issued. pc holds the halt address.
  - FETCH also latches the op/Rd/Rs/Rt fields onto the outputs. The fields stay stable from FETCH through SETTLE.
  - WAITSTEP: hold until a step edge -> ISSUE. step_mode is sampled at FETCH only.
  - ISSUE, 1 cycle: execute=1. Next state is SETTLE.
  - SETTLE: execute=0 for GAP cycles.
    - If pc==DEPTH-1 -> DONE (no wrap), with pc held.
    - Otherwise pc increments -> FETCH.
- Free-run throughput: one instruction per (1 FETCH + 1 ISSUE + GAP) cycles. With GAP=2 that is 4 cycles per instruction.
- execute is high for exactly one cycle per issued instruction and never in IDLE, DONE, FETCH or WAITSTEP.
- A start edge while busy is ignored. Steps and starts are not queued.
- Reset asserted mid-program returns everything to the reset values immediately. No partial execute pulse survives.
- Output fields are registered. There are no combinational paths from inputs to outputs.

Decomposition:
- Shared package alu_seq_pkg holds:
  - state encoding constants (IDLE=0 .. DONE=5)
  - instruction field bit positions (HALT_BIT=15, OP_HI/OP_LO, RD_HI/RD_LO, RS_HI/RS_LO, RT_HI/RT_LO)
  - opcode constants OP_ADD=000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_XOR=100, OP_SLL=101, OP_SRL=110, OP_SRA=111
- One sub-module: sync_edge_detect, covering the 2-flop synchroniser plus rising-edge pulse. It has the same clk/rst and is instantiated twice, for start and step.

Test Plan:
1. Load addr0=0x0123 (add r1=r2+r3), addr1=0x8000 (halt); step_mode=0; pulse start -> exactly one execute pulse with ALU_Operation=000, Rd=1, Rs=2, Rt=3; pc ends 1; done=1; busy=0.
2. Fill all 16 words, none halt, each word's Rd=its address, GAP=2 -> 16 execute pulses spaced exactly 4 cycles apart; pc stops at 15 with no wrap; done=1.
3. step_mode=1, program {0x1456, 0x8000} -> no execute until a step edge; execute occurs 3–4 cycles after the step-input rise, with ALU_Operation=001, Rd=4, Rs=5, Rt=6; holding step high does not issue twice.
4. Drop rst low during SETTLE of the 3rd instruction -> outputs go to 0 immediately; after release the state is IDLE; program contents are retained, so a rerun from start reproduces the identical execute sequence.
5. Start edge and prog_we to addr0 while busy -> program word unchanged and execution continues unperturbed; in DONE, a new start reruns from pc=0.
6. Word 0x8FFF at addr0 -> DONE after FETCH with zero execute pulses; pc=0.
